oram_posmap_frontend: RTL and testbench

//  Frontend stage directly upstream of PathORAMBackend. Owns an on-chip position map (valid bit + leaf per block).

---
 rtl/oram_frontend_pkg.sv | 52 +++++
 rtl/oram_posmap_frontend_if.sv | 55 +++++
 rtl/oram_posmap_frontend_ram.sv | 24 ++
 rtl/oram_posmap_frontend.sv | 152 +++++++++++++++
 tb/tb_oram_posmap_frontend.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oram_frontend_pkg.sv
// Shared types for the ORAM position-map frontend: backend/frontend command
// encodings, the frontend FSM states and the map-lookup decision.
package oram_frontend_pkg;

    localparam int BECMDWidth = 2;

    typedef enum logic [BECMDWidth-1:0] {
        BECMD_Update  = 2'd0,
        BECMD_Append  = 2'd1,
        BECMD_Read    = 2'd2,
        BECMD_ReadRmv = 2'd3
    } beCmd_t;

    typedef enum logic [1:0] {
        FECMD_Read   = 2'd0,
        FECMD_Write  = 2'd1,
        FECMD_Remove = 2'd2
    } feCmd_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOOKUP,
        ST_ISSUE,
        ST_WDATA,
        ST_RDATA,
        ST_ZERO
    } feState_t;

    typedef struct packed {
        logic   zero;
        beCmd_t cmd;
    } lookup_t;

    // The unused 2'b11 encoding is served as a read.
    function automatic feCmd_t feNormalize(logic [1:0] raw);
        return (raw == 2'b11) ? FECMD_Read : feCmd_t'(raw);
    endfunction

    // A read or remove of a block that was never written is answered locally.
    function automatic lookup_t feLookup(feCmd_t cmd, logic valid);
        lookup_t r;
        r.zero = 1'b0;
        case (cmd)
            FECMD_Write:  r.cmd = valid ? BECMD_Update : BECMD_Append;
            FECMD_Remove: begin r.cmd = BECMD_ReadRmv; r.zero = !valid; end
            default:      begin r.cmd = BECMD_Read;    r.zero = !valid; end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/oram_posmap_frontend_if.sv
// User-side and backend-side bundles of the position-map frontend. In both
// interfaces the master modport is the side that issues commands.
interface oram_fe_user_if #(
    parameter int PMAWidth = 10,
    parameter int FEDWidth = 64
);
    logic [1:0]          ReqCommand;
    logic [PMAWidth-1:0] ReqPAddr;
    logic                ReqValid;
    logic                ReqReady;
    logic [FEDWidth-1:0] ReqStoreData;
    logic                ReqStoreValid;
    logic                ReqStoreReady;
    logic [FEDWidth-1:0] RespLoadData;
    logic                RespLoadValid;
    logic                RespLoadReady;

    modport master (
        output ReqCommand, ReqPAddr, ReqValid, ReqStoreData, ReqStoreValid, RespLoadReady,
        input  ReqReady, ReqStoreReady, RespLoadData, RespLoadValid
    );
    modport slave (
        input  ReqCommand, ReqPAddr, ReqValid, ReqStoreData, ReqStoreValid, RespLoadReady,
        output ReqReady, ReqStoreReady, RespLoadData, RespLoadValid
    );
endinterface

interface oram_fe_backend_if #(
    parameter int ORAMU      = 32,
    parameter int ORAML      = 10,
    parameter int FEDWidth   = 64,
    parameter int BECMDWidth = 2
);
    logic [BECMDWidth-1:0] Command;
    logic [ORAMU-1:0]      PAddr;
    logic [ORAML-1:0]      CurrentLeaf;
    logic [ORAML-1:0]      RemappedLeaf;
    logic                  CommandValid;
    logic                  CommandReady;
    logic [FEDWidth-1:0]   StoreData;
    logic                  StoreValid;
    logic                  StoreReady;
    logic [FEDWidth-1:0]   LoadData;
    logic                  LoadValid;
    logic                  LoadReady;

    modport master (
        output Command, PAddr, CurrentLeaf, RemappedLeaf, CommandValid, StoreData, StoreValid, LoadReady,
        input  CommandReady, StoreReady, LoadData, LoadValid
    );
    modport slave (
        input  Command, PAddr, CurrentLeaf, RemappedLeaf, CommandValid, StoreData, StoreValid, LoadReady,
        output CommandReady, StoreReady, LoadData, LoadValid
    );
endinterface

// File: rtl/oram_posmap_frontend_ram.sv
// Position-map storage: 1R1W synchronous RAM, read-first on same-address
// collisions.
module oram_posmap_ram #(
    parameter int AddrWidth = 10,
    parameter int DataWidth = 11
) (
    input  logic                 Clock,
    input  logic                 WrEn,
    input  logic [AddrWidth-1:0] WrAddr,
    input  logic [DataWidth-1:0] WrData,
    input  logic                 RdEn,
    input  logic [AddrWidth-1:0] RdAddr,
    output logic [DataWidth-1:0] RdData
);

    logic [DataWidth-1:0] mem [2**AddrWidth];

    // NOTE: no reset on the array so it maps onto block RAM; the INIT sweep clears it.
    always_ff @(posedge Clock) begin
        if (WrEn) mem[WrAddr] <= WrData;
        if (RdEn) RdData <= mem[RdAddr];
    end

endmodule

// File: rtl/oram_posmap_frontend.sv
// Position-map frontend ahead of PathORAMBackend. Leaf source is selected by
// ORAM_FE_LFSR_LEAF_EN (defined: 32-bit Galois LFSR, undefined: up-counter).
module oram_posmap_frontend
    import oram_frontend_pkg::*;
#(
    parameter int          ORAMB    = 512,
    parameter int          ORAMU    = 32,
    parameter int          ORAML    = 10,
    parameter int          FEDWidth = 64,
    parameter int          PMAWidth = 10,
    parameter logic [31:0] LeafSeed = 32'h1
) (
    input logic           Clock,
    input logic           Reset,
    oram_fe_user_if.slave     User,
    oram_fe_backend_if.master Backend
);

    localparam int BlkChunks = ORAMB / FEDWidth;
    localparam int BeatWidth = $clog2(BlkChunks) + 1;
    localparam int MapWidth  = ORAML + 1;

    feState_t            state, nextState;
    feCmd_t              cmdReg;
    logic [PMAWidth-1:0] initCount, addrReg;
    logic [BeatWidth-1:0] beatCount;
    logic [31:0]         leafGen, leafNext;
    beCmd_t              commandReg;
    logic [ORAML-1:0]    currentLeafReg, remappedLeafReg;

    logic                mapWrEn, mapRdEn;
    logic [PMAWidth-1:0] mapWrAddr;
    logic [MapWidth-1:0] mapWrData, mapRdData;
    logic                beatFire, lastBeat, issueFire;
    lookup_t             lookup;

`ifdef ORAM_FE_LFSR_LEAF_EN
    assign leafNext = leafGen[0] ? ((leafGen >> 1) ^ 32'h8020_0003) : (leafGen >> 1);
`else
    assign leafNext = leafGen + 32'd1;
`endif

    assign lookup    = feLookup(cmdReg, mapRdData[ORAML]);
    assign lastBeat  = beatCount == BeatWidth'(BlkChunks - 1);
    assign issueFire = (state == ST_ISSUE) && Backend.CommandReady;

    assign Backend.Command      = commandReg;
    assign Backend.PAddr        = ORAMU'(addrReg);
    assign Backend.CurrentLeaf  = currentLeafReg;
    assign Backend.RemappedLeaf = remappedLeafReg;

    oram_posmap_ram #(.AddrWidth(PMAWidth), .DataWidth(MapWidth)) posMap (
        .Clock  (Clock),
        .WrEn   (mapWrEn),
        .WrAddr (mapWrAddr),
        .WrData (mapWrData),
        .RdEn   (mapRdEn),
        .RdAddr (User.ReqPAddr),
        .RdData (mapRdData)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= ST_INIT;
        else       state <= nextState;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        nextState             = state;
        User.ReqReady         = 1'b0;
        User.ReqStoreReady    = 1'b0;
        User.RespLoadData     = '0;
        User.RespLoadValid    = 1'b0;
        Backend.CommandValid  = 1'b0;
        Backend.StoreData     = '0;
        Backend.StoreValid    = 1'b0;
        Backend.LoadReady     = 1'b0;
        mapWrEn               = 1'b0;
        mapWrAddr             = addrReg;
        mapWrData             = '0;
        mapRdEn               = 1'b0;
        beatFire              = 1'b0;
        case (state)
            ST_INIT: begin
                mapWrEn   = 1'b1;
                mapWrAddr = initCount;
                if (initCount == '1) nextState = ST_IDLE;
            end
            ST_IDLE: begin
                User.ReqReady = 1'b1;
                mapRdEn       = User.ReqValid;
                if (User.ReqValid) nextState = ST_LOOKUP;
            end
            ST_LOOKUP: nextState = lookup.zero ? ST_ZERO : ST_ISSUE;
            ST_ISSUE: begin
                Backend.CommandValid = 1'b1;
                if (Backend.CommandReady) begin
                    mapWrEn   = 1'b1;
                    mapWrData = {cmdReg != FECMD_Remove, remappedLeafReg};
                    nextState = (commandReg == BECMD_Append || commandReg == BECMD_Update)
                              ? ST_WDATA : ST_RDATA;
                end
            end
            ST_WDATA: begin
                Backend.StoreData  = User.ReqStoreData;
                Backend.StoreValid = User.ReqStoreValid;
                User.ReqStoreReady = Backend.StoreReady;
                beatFire           = User.ReqStoreValid && Backend.StoreReady;
            end
            ST_RDATA: begin
                User.RespLoadData  = Backend.LoadData;
                User.RespLoadValid = Backend.LoadValid;
                Backend.LoadReady  = User.RespLoadReady;
                beatFire           = Backend.LoadValid && User.RespLoadReady;
            end
            ST_ZERO: begin
                User.RespLoadValid = 1'b1;
                beatFire           = User.RespLoadReady;
            end
            default: nextState = ST_INIT;
        endcase
        if (beatFire && lastBeat) nextState = ST_IDLE;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            initCount       <= '0;
            addrReg         <= '0;
            cmdReg          <= FECMD_Read;
            beatCount       <= '0;
            leafGen         <= LeafSeed;
            commandReg      <= BECMD_Update;
            currentLeafReg  <= '0;
            remappedLeafReg <= '0;
        end else begin
            if (state == ST_INIT) initCount <= initCount + 1'b1;
            if (state == ST_IDLE && User.ReqValid) begin
                addrReg <= User.ReqPAddr;
                cmdReg  <= feNormalize(User.ReqCommand);
            end
            // Command fields are frozen here and held through the ISSUE stall.
            if (state == ST_LOOKUP) begin
                commandReg      <= lookup.cmd;
                currentLeafReg  <= (lookup.cmd == BECMD_Append) ? '0 : mapRdData[ORAML-1:0];
                remappedLeafReg <= leafGen[ORAML-1:0];
            end
            if (issueFire) leafGen <= leafNext;
            if (beatFire) beatCount <= lastBeat ? '0 : beatCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_oram_posmap_frontend.sv
// Directed bench for oram_posmap_frontend in the default (counter leaf) build.
module tb_oram_posmap_frontend;
    import oram_frontend_pkg::*;

    localparam int PMAWidth = 10;
    localparam int FEDWidth = 64;
    localparam int ORAML    = 10;
    localparam int ORAMU    = 32;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    oram_fe_user_if    #(.PMAWidth(PMAWidth), .FEDWidth(FEDWidth)) User();
    oram_fe_backend_if #(.ORAMU(ORAMU), .ORAML(ORAML), .FEDWidth(FEDWidth),
                         .BECMDWidth(BECMDWidth)) Backend();

    oram_posmap_frontend #(
        .ORAMB(512), .ORAMU(ORAMU), .ORAML(ORAML), .FEDWidth(FEDWidth),
        .PMAWidth(PMAWidth), .LeafSeed(32'h1)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .User    (User),
        .Backend (Backend)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] obs [8];
    int          obsCount;
    bit          sawCmdValid;

    task automatic idle_inputs();
        User.ReqCommand       = 2'd0;
        User.ReqPAddr         = '0;
        User.ReqValid         = 1'b0;
        User.ReqStoreData     = '0;
        User.ReqStoreValid    = 1'b0;
        User.RespLoadReady    = 1'b0;
        Backend.CommandReady  = 1'b0;
        Backend.StoreReady    = 1'b0;
        Backend.LoadData      = '0;
        Backend.LoadValid     = 1'b0;
    endtask

    // Presents a request until accepted; returns at the negedge in LOOKUP.
    task automatic send_req(input logic [1:0] cmd, input logic [9:0] addr, output bit ok);
        User.ReqCommand = cmd;
        User.ReqPAddr   = addr;
        User.ReqValid   = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (User.ReqReady) begin ok = 1'b1; break; end
            @(negedge Clock);
        end
        @(negedge Clock);
        User.ReqValid = 1'b0;
    endtask

    task automatic wait_cmd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (Backend.CommandValid) begin ok = 1'b1; break; end
            @(negedge Clock);
        end
    endtask

    task automatic accept_cmd();
        Backend.CommandReady = 1'b1;
        @(negedge Clock);
        Backend.CommandReady = 1'b0;
    endtask

    task automatic run_store(input logic [63:0] base);
        obsCount = 0;
        for (int c = 0; c < 32 && obsCount < 8; c++) begin
            User.ReqStoreData  = base + 64'(obsCount);
            User.ReqStoreValid = 1'b1;
            Backend.StoreReady = 1'b1;
            #1;
            if (Backend.StoreValid && User.ReqStoreReady) begin
                obs[obsCount] = Backend.StoreData;
                obsCount++;
            end
            @(negedge Clock);
        end
        User.ReqStoreValid = 1'b0;
        Backend.StoreReady = 1'b0;
    endtask

    task automatic run_load(input logic [63:0] base);
        int k = 0;
        obsCount    = 0;
        sawCmdValid = 1'b0;
        for (int c = 0; c < 32 && obsCount < 8; c++) begin
            Backend.LoadData   = base + 64'(k);
            Backend.LoadValid  = 1'b1;
            User.RespLoadReady = 1'b1;
            #1;
            if (Backend.CommandValid) sawCmdValid = 1'b1;
            if (User.RespLoadValid && User.RespLoadReady) begin
                obs[obsCount] = User.RespLoadData;
                obsCount++;
                if (Backend.LoadReady) k++;
            end
            @(negedge Clock);
        end
        Backend.LoadValid  = 1'b0;
        User.RespLoadReady = 1'b0;
    endtask

    // Counts cycles with ReqReady low after Reset falls, checking backend valids stay low.
    task automatic init_sweep(input string tag);
        int cnt = 0;
        int bad = 0;
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            #1;
            if (User.ReqReady) break;
            if (Backend.CommandValid || Backend.StoreValid || Backend.LoadReady || User.RespLoadValid) bad++;
            cnt++;
            @(negedge Clock);
        end
        checks++;
        if (cnt !== 1024) begin
            errors++;
            $display("FAIL %s_init_cycles: got %0d want 1024", tag, cnt);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s_init_valids: %0d cycles with a valid high, want 0", tag, bad);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        #1;
        checks++;
        if ({User.ReqReady, Backend.CommandValid, Backend.StoreValid, Backend.LoadReady,
             User.RespLoadValid, User.ReqStoreReady} !== 6'b0) begin
            errors++;
            $display("FAIL reset_handshakes: got %b want 000000", {User.ReqReady, Backend.CommandValid,
                     Backend.StoreValid, Backend.LoadReady, User.RespLoadValid, User.ReqStoreReady});
        end
        checks++;
        if ({Backend.Command, Backend.PAddr, Backend.CurrentLeaf, Backend.RemappedLeaf} !== '0) begin
            errors++;
            $display("FAIL reset_cmd_fields: cmd=%0d paddr=%0d cur=%0d rem=%0d want all 0",
                     Backend.Command, Backend.PAddr, Backend.CurrentLeaf, Backend.RemappedLeaf);
        end
        init_sweep("reset");
    endtask

    task automatic test_write();
        bit ok, okc;
        // First write of addr 5 appends; the second updates the leaf just assigned.
        for (int pass = 0; pass < 2; pass++) begin
            send_req(FECMD_Write, 10'd5, ok);
            wait_cmd(okc);
            checks++;
            if (!(ok && okc)) begin
                errors++;
                $display("FAIL write%0d_handshake: req_ok=%0b cmd_ok=%0b want 1 1", pass, ok, okc);
            end
            checks++;
            if (Backend.Command !== (pass == 0 ? BECMD_Append : BECMD_Update) ||
                Backend.PAddr !== 32'd5 ||
                Backend.CurrentLeaf !== ORAML'(pass) ||
                Backend.RemappedLeaf !== ORAML'(pass + 1)) begin
                errors++;
                $display("FAIL write%0d_cmd: cmd=%0d paddr=%0d cur=%0d rem=%0d want %0d 5 %0d %0d",
                         pass, Backend.Command, Backend.PAddr, Backend.CurrentLeaf, Backend.RemappedLeaf,
                         pass == 0 ? 1 : 0, pass, pass + 1);
            end
            accept_cmd();
            run_store(64'(pass * 16));
            checks++;
            if (obsCount !== 8) begin
                errors++;
                $display("FAIL write%0d_beats: got %0d want 8", pass, obsCount);
            end
            for (int i = 0; i < 8 && i < obsCount; i++) begin
                checks++;
                if (obs[i] !== 64'(pass * 16 + i)) begin
                    errors++;
                    $display("FAIL write%0d_data[%0d]: got %0h want %0h", pass, i, obs[i], pass * 16 + i);
                end
            end
            #1;
            checks++;
            if (User.ReqReady !== 1'b1) begin
                errors++;
                $display("FAIL write%0d_ready_after: got %b want 1", pass, User.ReqReady);
            end
        end
    endtask

    task automatic test_read();
        bit ok, okc;
        int k = 0;
        int got = 0;
        int bad = 0;
        int stallBad = 0;
        send_req(FECMD_Read, 10'd5, ok);
        wait_cmd(okc);
        checks++;
        if (!(ok && okc) || Backend.Command !== BECMD_Read || Backend.CurrentLeaf !== 10'd2 ||
            Backend.RemappedLeaf !== 10'd3) begin
            errors++;
            $display("FAIL read_cmd: ok=%0b%0b cmd=%0d cur=%0d rem=%0d want 11 2 2 3",
                     ok, okc, Backend.Command, Backend.CurrentLeaf, Backend.RemappedLeaf);
        end
        accept_cmd();
        for (int c = 0; c < 40 && got < 8; c++) begin
            Backend.LoadData   = 64'(k);
            Backend.LoadValid  = 1'b1;
            User.RespLoadReady = (c >= 3);
            #1;
            if (c < 3 && (Backend.LoadReady !== 1'b0 || User.RespLoadValid !== 1'b1)) stallBad++;
            if (User.RespLoadValid && User.RespLoadReady) begin
                if (User.RespLoadData !== 64'(got)) bad++;
                got++;
                if (Backend.LoadReady) k++;
            end
            @(negedge Clock);
        end
        Backend.LoadValid  = 1'b0;
        User.RespLoadReady = 1'b0;
        checks++;
        if (stallBad !== 0) begin
            errors++;
            $display("FAIL read_stall: %0d stall cycles with LoadReady!=0 or RespLoadValid!=1", stallBad);
        end
        checks++;
        if (got !== 8 || bad !== 0 || k !== 8) begin
            errors++;
            $display("FAIL read_beats: got %0d beats, %0d wrong, %0d consumed; want 8 0 8", got, bad, k);
        end
        #1;
        checks++;
        if (User.ReqReady !== 1'b1) begin
            errors++;
            $display("FAIL read_ready_after: got %b want 1", User.ReqReady);
        end
    endtask

    task automatic test_zero(input logic [1:0] cmd, input logic [9:0] addr, input string tag);
        bit ok;
        int bad = 0;
        send_req(cmd, addr, ok);
        run_load(64'hDEAD_0000);
        for (int i = 0; i < 8 && i < obsCount; i++) if (obs[i] !== 64'd0) bad++;
        checks++;
        if (!ok || obsCount !== 8 || bad !== 0) begin
            errors++;
            $display("FAIL %s_beats: ok=%0b beats=%0d nonzero=%0d want 1 8 0", tag, ok, obsCount, bad);
        end
        checks++;
        if (sawCmdValid !== 1'b0) begin
            errors++;
            $display("FAIL %s_no_cmd: CommandValid seen=%b want 0", tag, sawCmdValid);
        end
        #1;
        checks++;
        if (User.ReqReady !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_after: got %b want 1", tag, User.ReqReady);
        end
    endtask

    task automatic test_remove();
        bit ok, okc;
        int bad = 0;
        send_req(FECMD_Remove, 10'd5, ok);
        wait_cmd(okc);
        checks++;
        if (!(ok && okc) || Backend.Command !== BECMD_ReadRmv || Backend.CurrentLeaf !== 10'd3 ||
            Backend.RemappedLeaf !== 10'd4) begin
            errors++;
            $display("FAIL remove_cmd: ok=%0b%0b cmd=%0d cur=%0d rem=%0d want 11 3 3 4",
                     ok, okc, Backend.Command, Backend.CurrentLeaf, Backend.RemappedLeaf);
        end
        accept_cmd();
        run_load(64'd100);
        for (int i = 0; i < 8 && i < obsCount; i++) if (obs[i] !== 64'(100 + i)) bad++;
        checks++;
        if (obsCount !== 8 || bad !== 0) begin
            errors++;
            $display("FAIL remove_beats: beats=%0d wrong=%0d want 8 0", obsCount, bad);
        end
        test_zero(FECMD_Read, 10'd5, "read_after_remove");
    endtask

    task automatic test_stall_and_reset();
        bit ok, okc;
        int unstable = 0;
        send_req(FECMD_Write, 10'd7, ok);
        wait_cmd(okc);
        for (int i = 0; i < 20; i++) begin
            if (Backend.CommandValid !== 1'b1 || Backend.Command !== BECMD_Append ||
                Backend.PAddr !== 32'd7 || Backend.CurrentLeaf !== 10'd0 ||
                Backend.RemappedLeaf !== 10'd5) unstable++;
            @(negedge Clock);
            #1;
        end
        checks++;
        if (!(ok && okc) || unstable !== 0) begin
            errors++;
            $display("FAIL stall_hold: ok=%0b%0b unstable=%0d want 11 0", ok, okc, unstable);
        end
        accept_cmd();
        for (int b = 0; b < 3; b++) begin
            User.ReqStoreData  = 64'(b);
            User.ReqStoreValid = 1'b1;
            Backend.StoreReady = 1'b1;
            @(negedge Clock);
        end
        Reset = 1'b1;
        #1;
        checks++;
        if ({Backend.StoreValid, User.ReqStoreReady, Backend.CommandValid, User.ReqReady} !== 4'b0 ||
            Backend.StoreData !== 64'd0) begin
            errors++;
            $display("FAIL midreset_valids: sv=%b rsr=%b cv=%b rr=%b sd=%0h want 0 0 0 0 0",
                     Backend.StoreValid, User.ReqStoreReady, Backend.CommandValid, User.ReqReady,
                     Backend.StoreData);
        end
        checks++;
        if ({Backend.Command, Backend.PAddr, Backend.CurrentLeaf, Backend.RemappedLeaf} !== '0) begin
            errors++;
            $display("FAIL midreset_cmd_fields: cmd=%0d paddr=%0d cur=%0d rem=%0d want all 0",
                     Backend.Command, Backend.PAddr, Backend.CurrentLeaf, Backend.RemappedLeaf);
        end
        idle_inputs();
        init_sweep("midreset");
    endtask

    task automatic test_after_reset();
        bit ok, okc;
        int bad = 0;
        // The aborted write to addr 7 was committed to the map before reset; INIT must clear it.
        test_zero(FECMD_Read, 10'd7, "cleared_map");
        send_req(FECMD_Write, 10'd3, ok);
        wait_cmd(okc);
        checks++;
        if (!(ok && okc) || Backend.Command !== BECMD_Append || Backend.RemappedLeaf !== 10'd1) begin
            errors++;
            $display("FAIL reseed_cmd: ok=%0b%0b cmd=%0d rem=%0d want 11 1 1",
                     ok, okc, Backend.Command, Backend.RemappedLeaf);
        end
        accept_cmd();
        run_store(64'd50);
        send_req(2'b11, 10'd3, ok);
        wait_cmd(okc);
        checks++;
        if (!(ok && okc) || Backend.Command !== BECMD_Read || Backend.PAddr !== 32'd3 ||
            Backend.CurrentLeaf !== 10'd1 || Backend.RemappedLeaf !== 10'd2) begin
            errors++;
            $display("FAIL illegal_cmd: ok=%0b%0b cmd=%0d paddr=%0d cur=%0d rem=%0d want 11 2 3 1 2",
                     ok, okc, Backend.Command, Backend.PAddr, Backend.CurrentLeaf, Backend.RemappedLeaf);
        end
        accept_cmd();
        run_load(64'd200);
        for (int i = 0; i < 8 && i < obsCount; i++) if (obs[i] !== 64'(200 + i)) bad++;
        checks++;
        if (obsCount !== 8 || bad !== 0) begin
            errors++;
            $display("FAIL illegal_cmd_beats: beats=%0d wrong=%0d want 8 0", obsCount, bad);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_zero(FECMD_Read, 10'd9, "read_unwritten");
        test_remove();
        test_stall_and_reset();
        test_after_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
